// File: rtl/ghost_mover.sv
// Ghost sprite mover: steps a sprite centre one STEP per frame inside a rectangular maze band,
// with a queued direction request, optional random turning at walls and a half-speed
// frightened mode that reverses the ghost on entry.
//
// Ports:
//   frame_clk         sole clock, state advances on its rising edge
//   Reset             asynchronous active-high reset
//   keycode[7:0]      direction request (04 left, 07 right, 16 down, 1A up; others ignored)
//   ai_en             pick a random legal direction when the current one is blocked
//   frighten          one-frame pulse entering/extending frightened mode
//   ghostX/ghostY     sprite centre position
//   ghostS            sprite half-size (constant)
//   dir[1:0]          current direction (0 left, 1 right, 2 down, 3 up)
//   moving            position changed on the last edge
//   mode[1:0]         0 idle, 1 move, 2 frightened
//   last_dirX/Y       last horizontal move was right / last vertical move was down
module ghost_mover #(
  parameter int unsigned X_START       = 50,
  parameter int unsigned Y_START       = 50,
  parameter int unsigned X_MIN         = 7,
  parameter int unsigned X_MAX         = 396,
  parameter int unsigned Y_MIN         = 7,
  parameter int unsigned Y_MAX         = 440,
  parameter int unsigned SIZE          = 10,
  parameter int unsigned STEP          = 1,
  parameter int unsigned FRIGHT_FRAMES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       ai_en,
  input  logic       frighten,
  output logic [9:0] ghostX,
  output logic [9:0] ghostY,
  output logic [9:0] ghostS,
  output logic [1:0] dir,
  output logic       moving,
  output logic [1:0] mode,
  output logic       last_dirX,
  output logic       last_dirY
);

  typedef enum logic [1:0] {StIdle = 2'd0, StMove = 2'd1, StFright = 2'd2} mode_e;

  // 11-bit bounds so the comparisons can never wrap.
  localparam logic [10:0] LeftMin    = 11'(X_MIN + SIZE + STEP);
  localparam logic [10:0] UpMin      = 11'(Y_MIN + SIZE + STEP);
  localparam logic [10:0] Reach      = 11'(SIZE + STEP);
  localparam logic [10:0] XLimit     = 11'(X_MAX);
  localparam logic [10:0] YLimit     = 11'(Y_MAX);
  localparam logic [15:0] FrightLoad = 16'(FRIGHT_FRAMES - 1);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d, pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        moving_q, moving_d;
  mode_e       mode_q, mode_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        last_x_q, last_x_d, last_y_q, last_y_d;

  logic        key_valid;
  logic [1:0]  key_dir;
  logic [3:0]  legal;
  logic [1:0]  eff_pend, rev_dir, mv_dir, cand;
  logic        eff_valid, step_en, mv_en;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = 2'd0;
    case (keycode)
      8'h04:   key_dir = 2'd0;
      8'h07:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h1A:   key_dir = 2'd3;
      default: key_valid = 1'b0;
    endcase
  end

  assign legal[0] = {1'b0, x_q} >= LeftMin;
  assign legal[1] = ({1'b0, x_q} + Reach) <= XLimit;
  assign legal[2] = ({1'b0, y_q} + Reach) <= YLimit;
  assign legal[3] = {1'b0, y_q} >= UpMin;

  // A request arriving this edge is usable immediately, as if already queued.
  assign eff_pend  = key_valid ? key_dir : pend_q;
  assign eff_valid = key_valid | pend_valid_q;
  // Encoding pairs opposites as {0,1} and {2,3}, so flipping bit 0 reverses.
  assign rev_dir   = dir_q ^ 2'b01;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    moving_d     = 1'b0;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    step_en      = 1'b0;
    mv_en        = 1'b0;
    mv_dir       = dir_q;
    cand         = 2'd0;

    if (key_valid) begin
      pend_d       = key_dir;
      pend_valid_d = 1'b1;
    end

    unique case (mode_q)
      StIdle: begin
        if (key_valid || ai_en) begin
          mode_d  = StMove;
          step_en = 1'b1;
        end
      end
      StMove: begin
        if (frighten) begin
          mode_d = StFright;
          cnt_d  = FrightLoad;
          if (legal[rev_dir]) dir_d = rev_dir;
        end else begin
          step_en = 1'b1;
        end
      end
      StFright: begin
        step_en = ~cnt_q[0];
        if (frighten)          cnt_d  = FrightLoad;
        else if (cnt_q == '0)  mode_d = StMove;
        else                   cnt_d  = cnt_q - 16'd1;
      end
      default: mode_d = StIdle;
    endcase

    if (step_en) begin
      if (eff_valid && legal[eff_pend]) begin
        mv_en        = 1'b1;
        mv_dir       = eff_pend;
        pend_valid_d = 1'b0;
      end else if (legal[dir_q]) begin
        mv_en = 1'b1;
      end else if (ai_en) begin
        for (int i = 0; i < 4; i++) begin
          cand = lfsr_q[1:0] + 2'(i);
          if (!mv_en && cand != dir_q && legal[cand]) begin
            mv_en  = 1'b1;
            mv_dir = cand;
          end
        end
      end
    end

    if (mv_en) begin
      dir_d    = mv_dir;
      moving_d = 1'b1;
      case (mv_dir)
        2'd0: begin x_d = x_q - 10'(STEP); last_x_d = 1'b0; end
        2'd1: begin x_d = x_q + 10'(STEP); last_x_d = 1'b1; end
        2'd2: begin y_d = y_q + 10'(STEP); last_y_d = 1'b1; end
        2'd3: begin y_d = y_q - 10'(STEP); last_y_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_q          <= 10'(X_START);
      y_q          <= 10'(Y_START);
      dir_q        <= 2'd0;
      pend_q       <= 2'd0;
      pend_valid_q <= 1'b0;
      moving_q     <= 1'b0;
      mode_q       <= StIdle;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      last_x_q     <= 1'b0;
      last_y_q     <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      moving_q     <= moving_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
    end
  end

  assign ghostX    = x_q;
  assign ghostY    = y_q;
  assign ghostS    = 10'(SIZE);
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign mode      = mode_q;
  assign last_dirX = last_x_q;
  assign last_dirY = last_y_q;

endmodule
